// File: rtl/simple_uart_tx_if.sv
// simple_uart_tx_if - data-bus device port of the UART transmitter.
//   req_i/we_i/be_i/addr_i/wdata_i : request, driven by the bus master
//   rvalid_o/rdata_o/err_o         : response, one cycle after req_i
// The signal names keep the device-side direction suffixes so the bus port
// reads the same as the rest of the simple-system peripherals.
interface simple_uart_tx_if #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
);
    logic                    req_i;
    logic                    we_i;
    logic [3:0]              be_i;
    logic [AddressWidth-1:0] addr_i;
    logic [DataWidth-1:0]    wdata_i;
    logic                    rvalid_o;
    logic [DataWidth-1:0]    rdata_o;
    logic                    err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/simple_uart_tx.sv
// simple_uart_tx - memory-mapped 8N1 UART transmitter with a TX FIFO.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : simple_uart_tx_if.slave (TXDATA 0x0, STATUS 0x4, CTRL 0x8)
//   tx_o         : serial output, idle high
//   irq_o        : registered level IRQ, IRQEN & FIFO empty & transmitter idle
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit,
// gated at run time by CTRL[17] PAREN.
module simple_uart_tx #(
    parameter int AddressWidth   = 32,
    parameter int DataWidth      = 32,
    parameter int FifoDepth      = 8,
    parameter int DefaultBaudDiv = 868
) (
    input  logic              clk_i,
    input  logic              rst_i,
    simple_uart_tx_if.slave   bus,
    output logic              tx_o,
    output logic              irq_o
);
    localparam int PW = $clog2(FifoDepth);
    localparam int LW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ---------------- bus decode ----------------
    logic [7:0] off;
    logic       sel_tx, sel_st, sel_ctrl;
    logic       wr_tx, wr_ctrl;

    assign off      = bus.addr_i[9:2];
    assign sel_tx   = (off == 8'd0);
    assign sel_st   = (off == 8'd1);
    assign sel_ctrl = (off == 8'd2);
    assign wr_tx    = bus.req_i & bus.we_i & sel_tx & bus.be_i[0];
    assign wr_ctrl  = bus.req_i & bus.we_i & sel_ctrl;

    // ---------------- CTRL ----------------
    logic [15:0] baud_q;
    logic        irqen_q;
`ifdef UART_TX_PARITY_EN
    logic        paren_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            baud_q  <= 16'(DefaultBaudDiv);
            irqen_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            paren_q <= 1'b0;
`endif
        end else if (wr_ctrl) begin
            if (bus.be_i[0]) baud_q[7:0]  <= bus.wdata_i[7:0];
            if (bus.be_i[1]) baud_q[15:8] <= bus.wdata_i[15:8];
            if (bus.be_i[2]) begin
                irqen_q <= bus.wdata_i[16];
`ifdef UART_TX_PARITY_EN
                paren_q <= bus.wdata_i[17];
`endif
            end
        end
    end

    // ---------------- TX FIFO ----------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [7:0]  mem [FifoDepth];
    logic [PW:0] wptr_q, rptr_q;
    logic [LW-1:0] level;
    logic        full, empty, push, pop;
    logic [7:0]  fifo_head;

    assign level     = wptr_q - rptr_q;
    assign full      = (level == LW'(FifoDepth));
    assign empty     = (wptr_q == rptr_q);
    // Fullness is taken before any same-cycle pop: a push into a full FIFO
    // is refused even if the serialiser frees a slot in that cycle.
    assign push      = wr_tx & ~full;
    assign fifo_head = mem[rptr_q[PW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q[PW-1:0]] <= bus.wdata_i[7:0];
    end

    // ---------------- serialiser FSM ----------------
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, reload;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tick;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    // Bit period is max(BAUDDIV,1); the counter runs period-1 .. 0 and is
    // reloaded from the live BAUDDIV at every bit boundary.
    assign reload = (baud_q == 16'd0) ? 16'd0 : baud_q - 16'd1;
    assign tick   = (cnt_q == 16'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    shift_d = fifo_head;
                    cnt_d   = reload;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^fifo_head;
`endif
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    cnt_d   = reload;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d = reload;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = paren_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    cnt_d   = reload;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    // Queued data goes straight into the next START bit so
                    // back-to-back frames have no idle gap.
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                        shift_d = fifo_head;
                        cnt_d   = reload;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^fifo_head;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_o = 1'b1;
        case (state_q)
            S_START:  tx_o = 1'b0;
            S_DATA:   tx_o = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_o = par_q;
`endif
            default:  tx_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) irq_o <= 1'b0;
        else       irq_o <= irqen_q & empty & (state_q == S_IDLE);
    end

    // ---------------- bus response ----------------
    logic [31:0] status, ctrl, rd_d;
    logic        err_d;

    assign status = {20'b0, 4'(level), 5'b0, (state_q != S_IDLE), empty, full};
`ifdef UART_TX_PARITY_EN
    assign ctrl   = {14'b0, paren_q, irqen_q, baud_q};
`else
    assign ctrl   = {15'b0, irqen_q, baud_q};
`endif

    always_comb begin
        rd_d  = '0;
        err_d = 1'b0;
        if (sel_st)        rd_d  = status;
        else if (sel_ctrl) rd_d  = ctrl;
        else if (!sel_tx)  err_d = 1'b1;
        if (wr_tx && full) err_d = 1'b1;
        if (bus.we_i)      rd_d  = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.rvalid_o <= 1'b0;
            bus.err_o    <= 1'b0;
            bus.rdata_o  <= '0;
        end else begin
            bus.rvalid_o <= bus.req_i;
            bus.err_o    <= bus.req_i & err_d;
            bus.rdata_o  <= bus.req_i ? DataWidth'(rd_d) : '0;
        end
    end

    logic unused_bits;
`ifdef UART_TX_PARITY_EN
    assign unused_bits = ^{bus.addr_i[AddressWidth-1:10], bus.addr_i[1:0],
                           bus.be_i[3], bus.wdata_i[DataWidth-1:18]};
`else
    assign unused_bits = ^{bus.addr_i[AddressWidth-1:10], bus.addr_i[1:0],
                           bus.be_i[3], bus.wdata_i[DataWidth-1:17]};
`endif
endmodule
